// File: rtl/pll_supervisor_pkg.sv
// Shared types and defaults for the PLL supervisor: state encoding, timing
// defaults for a 16 MHz reference, and status counter widths.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int DEF_LOCK_TIMEOUT = 16000;
  localparam int DEF_RESET_PULSE  = 16;
  localparam int DEF_LOCK_STABLE  = 1600;
  localparam int DEF_MAX_RETRIES  = 7;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // Width of the shared phase counter: just enough to hold the longest phase minus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow-changing level signals.
// Latency: two clk edges; no flow control.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// Sequences SB_PLL40 RESETB, qualifies LOCK, and gates the fast-domain reset.
// Outputs registered from next state; lock decisions lag the pin by the 2-flop sync; no backpressure.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RESET_PULSE  = DEF_RESET_PULSE,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               locked,
  input  logic               relock,
  output logic               pll_resetb,
  output logic               sys_reset,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOSS_W-1:0]  loss_count
);

  localparam int CNT_W = cnt_width(LOCK_TIMEOUT, RESET_PULSE, LOCK_STABLE);

  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
  localparam logic [LOSS_W-1:0]  LOSS_ONE     = LOSS_W'(1);
  localparam bit                 RETRY_CAPPED = (MAX_RETRIES != 0);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clock_in),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic [RETRY_W-1:0] retry_nxt;
  logic [RETRY_W-1:0] retry_inc;
  logic [LOSS_W-1:0]  loss_nxt;
  logic [LOSS_W-1:0]  loss_inc;

  assign retry_inc = (retry_count == '1) ? retry_count : retry_count + RETRY_ONE;
  assign loss_inc  = (loss_count  == '1) ? loss_count  : loss_count  + LOSS_ONE;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    loss_nxt  = loss_count;

    case (state)
      RESET_PLL: begin
        if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins over a retry.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry_inc;
          state_nxt = (RETRY_CAPPED && retry_inc == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET_PLL;
          loss_nxt  = loss_inc;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RESET_PLL;
      end
    endcase

    // Host re-lock overrides everything, including a lock drop on the same cycle.
    if (relock) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
      loss_nxt  = loss_count;
    end
  end

  assign cnt_clr = relock || (state_nxt != state);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      state       <= state_nxt;
      retry_count <= retry_nxt;
      loss_count  <= loss_nxt;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
      pll_resetb <= !(state_nxt == RESET_PLL || state_nxt == FAULT);
      sys_reset  <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
      fault      <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: phase/elapsed-time model checked every cycle plus directed timing checks.
module tb_pll_supervisor;

  localparam int LOCK_TIMEOUT = 20;
  localparam int RESET_PULSE  = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRIES  = 2;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       relock;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  pll_supervisor #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RESET_PULSE  (RESET_PULSE),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .locked      (locked),
    .relock      (relock),
    .pll_resetb  (pll_resetb),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase plus the edge it was entered on; lock_s is the pin delayed two edges.
  localparam int P_PULSE = 0, P_WAIT = 1, P_QUAL = 2, P_RUN = 3, P_FAULT = 4;
  int   m_ph    = P_PULSE;
  int   t0      = 0;
  int   m_retry = 0;
  int   m_loss  = 0;
  bit   m_valid = 0;
  bit   lk_q[$] = '{1'b0, 1'b0};
  bit   ls;
  int   el;

  task automatic go(input int p);
    m_ph = p;
    t0   = cyc;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      go(P_PULSE);
      m_retry = 0;
      m_loss  = 0;
      lk_q    = '{1'b0, 1'b0};
      m_valid = 1;
    end else begin
      ls = lk_q[0];
      void'(lk_q.pop_front());
      lk_q.push_back(locked);
      el = cyc - t0;
      if (relock) begin
        go(P_PULSE);
        m_retry = 0;
      end else begin
        case (m_ph)
          P_PULSE: if (el == RESET_PULSE) go(P_WAIT);
          P_WAIT: begin
            if (ls) go(P_QUAL);
            else if (el == LOCK_TIMEOUT) begin
              m_retry = (m_retry < 15) ? m_retry + 1 : 15;
              if (MAX_RETRIES != 0 && m_retry == MAX_RETRIES) go(P_FAULT);
              else go(P_PULSE);
            end
          end
          P_QUAL: begin
            if (!ls) go(P_WAIT);
            else if (el == LOCK_STABLE) begin
              go(P_RUN);
              m_retry = 0;
            end
          end
          P_RUN: if (!ls) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            go(P_PULSE);
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pll_resetb", pll_resetb, (m_ph == P_PULSE || m_ph == P_FAULT) ? 0 : 1);
      chk("sys_reset", sys_reset, (m_ph == P_RUN) ? 0 : 1);
      chk("ready", ready, (m_ph == P_RUN) ? 1 : 0);
      chk("fault", fault, (m_ph == P_FAULT) ? 1 : 0);
      chk("retry_count", retry_count, m_retry);
      chk("loss_count", loss_count, m_loss);
    end
  end

  function automatic logic out_sel(input int s);
    case (s)
      0:       return pll_resetb;
      1:       return sys_reset;
      2:       return ready;
      default: return fault;
    endcase
  endfunction

  // Negedges until the selected output equals v; -1 if the budget runs out.
  task automatic wait_val(input int s, input logic v, input int max, output int n);
    n = 0;
    while (out_sel(s) !== v) begin
      @(negedge clk);
      n++;
      if (n > max) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic count_low(input int max, output int n);
    n = 0;
    while (pll_resetb !== 1'b1 && n <= max) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int tmo;
    reset  = 1'b1;
    locked = 1'b0;
    relock = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_pll_resetb", pll_resetb, 0);
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_loss", loss_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1. Nominal lock
    count_low(10, n);
    chk("t1_pulse_len", n, 4);
    repeat (6) @(negedge clk);
    locked = 1'b1;
    wait_val(2, 1'b1, 100, n);
    chk("t1_ready_latency", n, 11);
    chk("t1_sys_reset", sys_reset, 0);
    chk("t1_retry", retry_count, 0);

    // 4. Single-cycle loss in RUN
    repeat (3) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_val(1, 1'b1, 20, n);
    chk("t4_sys_reset_latency", (n < 0) ? -1 : n + 1, 3);
    chk("t4_pll_resetb_low", pll_resetb, 0);
    chk("t4_loss", loss_count, 1);
    wait_val(2, 1'b1, 100, n);
    chk("t4_ready_back", ready, 1);

    // 5. relock on the same cycle the synced lock drops in RUN
    repeat (2) @(negedge clk);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    locked = 1'b1;
    chk("t5_pll_resetb", pll_resetb, 0);
    chk("t5_sys_reset", sys_reset, 1);
    chk("t5_loss_unchanged", loss_count, 1);
    wait_val(2, 1'b1, 100, n);
    chk("t5_ready_back", ready, 1);

    // 3. Unstable lock during qualification
    @(negedge clk);
    relock = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    relock = 1'b0;
    count_low(10, n);
    chk("t3_pulse_len", n, 4);
    repeat (2) @(negedge clk);
    locked = 1'b1;
    repeat (8) @(negedge clk);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_ready_held", ready, 0);
    locked = 1'b1;
    wait_val(2, 1'b1, 100, n);
    chk("t3_ready_latency", n, 11);
    chk("t3_retry", retry_count, 0);

    // 2. Timeouts into FAULT, then relock
    @(negedge clk);
    relock = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    relock = 1'b0;
    count_low(10, n);
    chk("t2_pulse1_len", n, 4);
    wait_val(0, 1'b0, 100, n);
    chk("t2_gap1", (n < 0) ? -1 : n + 4, 24);
    chk("t2_retry1", retry_count, 1);
    count_low(10, n);
    chk("t2_pulse2_len", n, 4);
    wait_val(0, 1'b0, 100, n);
    chk("t2_gap2", (n < 0) ? -1 : n + 4, 24);
    chk("t2_fault", fault, 1);
    chk("t2_retry2", retry_count, 2);
    repeat (30) @(negedge clk);
    chk("t2_fault_hold", fault, 1);
    chk("t2_resetb_hold", pll_resetb, 0);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    chk("t2_fault_clear", fault, 0);
    chk("t2_retry_clear", retry_count, 0);
    count_low(10, n);
    chk("t2_relock_pulse", n, 4);

    // 6. reset mid-WAIT_LOCK with one retry counted
    wait_val(0, 1'b0, 100, n);
    chk("t6_retry_before", retry_count, 1);
    count_low(10, n);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_pll_resetb", pll_resetb, 0);
    chk("t6_sys_reset", sys_reset, 1);
    chk("t6_ready", ready, 0);
    chk("t6_fault", fault, 0);
    chk("t6_retry", retry_count, 0);
    chk("t6_loss", loss_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Saturation: 256 losses from a clean reset
    count_low(10, n);
    locked = 1'b1;
    wait_val(2, 1'b1, 100, n);
    chk("sat_start_ready", ready, 1);
    tmo = 0;
    for (int i = 0; i < 256; i++) begin
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      wait_val(2, 1'b0, 20, n);
      if (n < 0) tmo++;
      wait_val(2, 1'b1, 100, n);
      if (n < 0) tmo++;
    end
    chk("sat_timeouts", tmo, 0);
    chk("sat_loss", loss_count, 255);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
